// File: rtl/prog_mem_if.sv
// Fetch port and program-loader port of prog_mem, bundled for connection.
// The master drives requests and beats; the slave (prog_mem) returns fetch data and load status.
interface prog_mem_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              busy;
  logic              ld_done;
  logic              ld_overflow;
  logic [ADDR_W:0]   ld_count;

  modport master (
    output fetch_en, fetch_addr, ld_start, ld_valid, ld_data, ld_last,
    input  fetch_data, fetch_valid, ld_ready, busy, ld_done, ld_overflow, ld_count
  );

  modport slave (
    input  fetch_en, fetch_addr, ld_start, ld_valid, ld_data, ld_last,
    output fetch_data, fetch_valid, ld_ready, busy, ld_done, ld_overflow, ld_count
  );
endinterface

// File: rtl/prog_mem.sv
// Program memory with a streaming loader; unwritten words read as DEFAULT_WORD.
// Fetch latency 1 cycle, only while idle; loader beats accepted every cycle in LOAD (ld_ready = busy).
module prog_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(8'hF0)
) (
  input  logic      clk,
  input  logic      rst_n,
  prog_mem_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_valid_q;
  logic              done_q;
  logic              overflow_q;

  logic              load_start;
  logic              beat_acc;
  logic              load_end;
  logic              fetch_acc;
  logic              ld_ready_c;
  logic              busy_c;
  logic              at_end;
  logic [DATA_W-1:0] read_word;

  assign at_end = &ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    beat_acc   = 1'b0;
    load_end   = 1'b0;
    fetch_acc  = 1'b0;
    ld_ready_c = 1'b0;
    busy_c     = 1'b0;
    case (state_q)
      IDLE: begin
        // A fetch coinciding with ld_start still sees the pre-load contents.
        fetch_acc = bus.fetch_en;
        if (bus.ld_start) begin
          load_start = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        ld_ready_c = 1'b1;
        busy_c     = 1'b1;
        beat_acc   = bus.ld_valid;
        if (beat_acc && (bus.ld_last || at_end)) begin
          load_end = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q  <= '0;
      ptr_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= load_end;
      if (load_start) begin
        written_q  <= '0;
        ptr_q      <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (beat_acc) begin
        written_q[ptr_q] <= 1'b1;
        // The last slot ends the load, so the pointer never wraps.
        if (!at_end) begin
          ptr_q <= ptr_q + 1'b1;
        end
        if (count_q != COUNT_MAX) begin
          count_q <= count_q + 1'b1;
        end
        if (at_end && !bus.ld_last) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  // Array contents are left unreset; the written bitmap masks stale words.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      mem[ptr_q] <= bus.ld_data;
    end
  end

  assign read_word = written_q[bus.fetch_addr] ? mem[bus.fetch_addr] : DEFAULT_WORD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_data_q  <= DEFAULT_WORD;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_acc;
      if (fetch_acc) begin
        fetch_data_q <= read_word;
      end
    end
  end

  assign bus.fetch_data  = fetch_data_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.ld_ready    = ld_ready_c;
  assign bus.busy        = busy_c;
  assign bus.ld_done     = done_q;
  assign bus.ld_overflow = overflow_q;
  assign bus.ld_count    = count_q;
endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 8, instruction word width.
REQ-003 Parameter DEFAULT_WORD, default 8'b1111_0000 (JMP 0), value returned for unwritten words.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 fetch_en  input  1  fetch request this cycle.
REQ-007 fetch_addr  input  ADDR_W  fetch address.
REQ-008 fetch_data  output  DATA_W  registered instruction word.
REQ-009 fetch_valid  output  1  fetch_data holds the result of the previous cycle's accepted fetch.
REQ-010 ld_start  input  1  single-cycle pulse; begins a program load.
REQ-011 ld_valid  input  1  loader beat valid.
REQ-012 ld_data  input  DATA_W  loader beat word.
REQ-013 ld_last  input  1  marks final beat; qualified by ld_valid.
REQ-014 ld_ready  output  1  block accepts a beat this cycle.
REQ-015 busy  output  1  high while in LOAD.
REQ-016 ld_done  output  1  one-cycle pulse on load completion.
REQ-017 ld_overflow  output  1  sticky; memory filled before ld_last seen.
REQ-018 ld_count  output  ADDR_W+1  words written by the current/last load.

Function
REQ-019 Storage: DEPTH x DATA_W array plus DEPTH-bit written bitmap; read value = array word if bitmap bit set, else DEFAULT_WORD.
REQ-020 States: IDLE, LOAD; reset enters IDLE.
REQ-021 IDLE: ld_ready=0, busy=0; ld_start=1 -> next cycle LOAD, bitmap cleared, write pointer=0, ld_count=0, ld_overflow=0.
REQ-022 LOAD: ld_ready=1, busy=1; beat accepted when ld_valid&ld_ready; writes ld_data to array[ptr], sets bitmap[ptr], ptr+1, ld_count+1.
REQ-023 LOAD exit on accepted beat with ld_last=1 -> IDLE, ld_done=1 next cycle.
REQ-024 LOAD exit on accepted beat at ptr=DEPTH-1 with ld_last=0 -> IDLE, ld_done=1, ld_overflow=1; no wrap, no further writes.
REQ-025 Beat at ptr=DEPTH-1 with ld_last=1 -> normal completion, ld_overflow=0.
REQ-026 ld_start in LOAD ignored; ld_valid in IDLE ignored (no write).
REQ-027 Fetch: accepted when fetch_en=1 and state IDLE; fetch_data/fetch_valid update next cycle (1-cycle latency); fetch_valid=0 following any cycle without accepted fetch.
REQ-028 Fetch during LOAD not accepted (fetch_valid=0 next cycle); fetch_data holds previous value.
REQ-029 ld_start and fetch_en same IDLE cycle: fetch accepted against pre-load contents; LOAD begins next cycle.
REQ-030 Fetch in the cycle after completion sees the newly loaded words.
REQ-031 ld_count saturates at DEPTH; holds after load until next ld_start.

Reset
REQ-032 rst_n=0 asynchronously: state IDLE, bitmap all 0, ptr=0, fetch_data=DEFAULT_WORD, fetch_valid=0, ld_done=0, ld_overflow=0, ld_count=0, busy=0, ld_ready=0; array contents need not be cleared.
REQ-033 Reset mid-LOAD aborts load; all words read DEFAULT_WORD afterwards.

Verification
REQ-034 Reset, fetch addr 0..15 -> each fetch_data=8'hF0, fetch_valid=1 one cycle after each request.
REQ-035 Load 7 beats 70,20,01,01,40,90,F6 (hex) with ld_last on 7th -> ld_done pulse, ld_count=7; fetch addr 6 -> F6, addr 7 -> F0.
REQ-036 Load with ld_valid gaps and fetch_en held high during LOAD -> no fetch_valid during LOAD, writes only on valid beats, contents correct afterwards.
REQ-037 Load 16 beats without ld_last -> ld_overflow=1, ld_count=16, 17th beat not accepted (ld_ready=0), addr 0 unchanged.
REQ-038 rst_n low after 3 beats of a load -> busy=0 immediately, all fetches return F0.
REQ-039 ADDR_W=6, DATA_W=16: load 64 words with ld_last on 64th -> ld_overflow=0, ld_count=64, readback matches.
